// File: rtl/zoran_nios_send_addr.sv
// zoran_nios_send_addr: Avalon-MM slave that queues bytes in a small FIFO and
// sends them to a peer over out_port/out_valid.
// Optional feature macro: ZORAN_SEND_ACK_EN. When it is defined, each transfer
// waits for a rising edge on the peer's ack_in. When it is undefined, the wait is
// replaced by a fixed gap of HOLD+1 idle cycles and ack_in is ignored.
module zoran_nios_send_addr #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_RESET = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ack_in,
  output logic [7:0]  out_port,
  output logic        out_valid,
  output logic        irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT} state_t;

  state_t           state, state_nxt;
  logic [7:0]       hold_cnt, hold_nxt;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [4:0]       fifo_count;
  logic [9:0]       config_reg;
  logic [1:0]       event_reg;
  logic             wr, data_wr, status_wr, config_wr, event_wr;
  logic             flush, abort, full, empty, push, pop, done_set;
  logic [1:0]       event_clr, event_set;
  logic             unused_bits;

  assign wr        = chipselect & ~write_n;
  assign data_wr   = wr && (address == 2'd0);
  assign status_wr = wr && (address == 2'd1);
  assign config_wr = wr && (address == 2'd2);
  assign event_wr  = wr && (address == 2'd3);
  assign flush     = status_wr & writedata[0];
  assign abort     = status_wr & writedata[1];

  // Fullness is taken from the registered count, so a pop in the same cycle never rescues a write.
  assign full  = (fifo_count == DEPTH_CNT);
  assign empty = (fifo_count == 5'd0);
  assign push  = data_wr & ~full & ~flush;

  assign event_clr = event_wr ? writedata[1:0] : 2'b00;
  assign event_set = {data_wr & full, done_set};
  assign irq       = |(event_reg & config_reg[9:8]);

`ifdef ZORAN_SEND_ACK_EN
  logic ack_meta, ack_s1, ack_s2, ack_rise;

  assign ack_rise    = ack_s1 & ~ack_s2;
  assign unused_bits = ^writedata[31:10];

  // Two-flop synchronizer for the peer acknowledge plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_meta <= 1'b0;
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
    end else begin
      ack_meta <= ack_in;
      ack_s1   <= ack_meta;
      ack_s2   <= ack_s1;
    end
  end
`else
  logic [7:0] hold_lat;

  assign unused_bits = ^{writedata[31:10], ack_in, abort};

  // Keep the HOLD value sampled in SETUP so the gap matches the strobe of the same transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_lat <= 8'd0;
    else if (state == ST_SETUP) hold_lat <= config_reg[7:0];
  end
`endif

  // Transmit FSM next-state logic: pop, setup, timed strobe, then wait for ack or gap.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    pop       = 1'b0;
    done_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !flush) begin
          pop       = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        hold_nxt  = config_reg[7:0];
        state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        if (hold_cnt == 8'd0) begin
          state_nxt = ST_WAIT;
`ifndef ZORAN_SEND_ACK_EN
          hold_nxt  = hold_lat;
`endif
        end else begin
          hold_nxt = hold_cnt - 8'd1;
        end
      end
      ST_WAIT: begin
`ifdef ZORAN_SEND_ACK_EN
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (ack_rise) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
`else
        if (hold_cnt == 8'd0) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          hold_nxt = hold_cnt - 8'd1;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, hold counter, output byte and registered strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= 8'd0;
      out_port  <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      out_valid <= (state_nxt == ST_STROBE);
      if (pop) out_port <= fifo_mem[rd_ptr];
    end
  end

  // FIFO storage has no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= writedata[7:0];
  end

  // FIFO pointers and occupancy; a flush empties the queue without touching the active transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 5'd0;
    end else if (flush) begin
      rd_ptr     <= wr_ptr;
      fifo_count <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // CONFIG register and sticky EVENT bits; a write-1 clear beats a same-cycle set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      config_reg <= {2'b00, 8'(HOLD_RESET)};
      event_reg  <= 2'b00;
    end else begin
      if (config_wr) config_reg <= writedata[9:0];
      event_reg <= (event_reg | event_set) & ~event_clr;
    end
  end

  // Registered read mux, updated every cycle from the current address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      case (address)
        2'd0:    readdata <= {24'd0, out_port};
        2'd1:    readdata <= {23'd0, fifo_count, 1'b0, empty, full, state != ST_IDLE};
        2'd2:    readdata <= {22'd0, config_reg};
        default: readdata <= {30'd0, event_reg};
      endcase
    end
  end

endmodule

// File: tb/tb_zoran_nios_send_addr.sv
// tb_zoran_nios_send_addr: directed bench for the byte transmitter.
// Works with or without ZORAN_SEND_ACK_EN; the transfer-completion helpers
// pulse ack_in only when the acknowledge handshake is built in.
module tb_zoran_nios_send_addr;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        ack_in = 1'b0;
  logic [7:0]  out_port;
  logic        out_valid;
  logic        irq;

  int check_count = 0;
  int fail_count  = 0;
  logic [31:0] rd;

  zoran_nios_send_addr #(.FIFO_DEPTH(4), .HOLD_RESET(3)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .ack_in(ack_in),
    .out_port(out_port), .out_valid(out_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus write; called at a negedge, the write lands on the following posedge.
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk);
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic waitStrobeHigh(input string tag, input logic [7:0] exp);
    int n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("strobe_timeout", 32'(n >= 200), 32'd0);
    checkOutput(tag, {24'd0, out_port}, {24'd0, exp});
  endtask

  task automatic finishTransfer();
    int n = 0;
    while (out_valid !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("strobe_fall_timeout", 32'(n >= 200), 32'd0);
`ifdef ZORAN_SEND_ACK_EN
    @(negedge clk) ack_in = 1'b1;
    repeat (4) @(negedge clk);
    ack_in = 1'b0;
    repeat (3) @(negedge clk);
`endif
  endtask

  task automatic waitIdle();
    int n = 0;
    logic [31:0] s;
    busRead(2'd1, s);
    while (s[0] && n < 100) begin
      busRead(2'd1, s);
      n++;
    end
    checkOutput("idle_timeout", 32'(n >= 100), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;

    // Reset values
    #12;
    checkOutput("rst_out_port", {24'd0, out_port}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_readdata", readdata, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    busRead(2'd0, rd); checkOutput("rst_data", rd, 32'h0);
    busRead(2'd1, rd); checkOutput("rst_status", rd, 32'h4);
    busRead(2'd2, rd); checkOutput("rst_config", rd, 32'h003);
    busRead(2'd3, rd); checkOutput("rst_event", rd, 32'h0);

    // Single byte with HOLD=3 and done interrupt enabled
    applyStimulus(2'd2, 32'h103);
    applyStimulus(2'd0, 32'hA5);
    @(posedge clk); #1;
    checkOutput("t1_out_port", {24'd0, out_port}, 32'hA5);
    checkOutput("t1_valid_lo", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("t1_valid_hi", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    checkOutput("t1_valid_end", {31'd0, out_valid}, 32'd0);
`ifdef ZORAN_SEND_ACK_EN
    @(negedge clk) ack_in = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("t1_irq_early", {31'd0, irq}, 32'd0);
    end
`else
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("t1_irq_early", {31'd0, irq}, 32'd0);
    end
`endif
    @(posedge clk); #1;
    checkOutput("t1_irq_done", {31'd0, irq}, 32'd1);
    @(negedge clk) ack_in = 1'b0;
    busRead(2'd3, rd); checkOutput("t1_event", rd, 32'h1);
    busRead(2'd0, rd); checkOutput("t1_data_rd", rd, 32'hA5);
    applyStimulus(2'd3, 32'h1);
    checkOutput("t1_irq_clr", {31'd0, irq}, 32'd0);
    busRead(2'd1, rd); checkOutput("t1_status", rd, 32'h4);

    // Done set and write-1 clear land on the same edge
    applyStimulus(2'd0, 32'h3C);
`ifdef ZORAN_SEND_ACK_EN
    repeat (6) @(negedge clk);
    ack_in = 1'b1;
    repeat (2) @(negedge clk);
`else
    repeat (9) @(negedge clk);
`endif
    checkOutput("t2_pre_irq", {31'd0, irq}, 32'd0);
    applyStimulus(2'd3, 32'h1);
    ack_in = 1'b0;
    checkOutput("t2_irq", {31'd0, irq}, 32'd0);
    busRead(2'd3, rd); checkOutput("t2_event", rd, 32'h0);
    busRead(2'd1, rd); checkOutput("t2_status", rd, 32'h4);
    repeat (3) @(negedge clk);

    // Overflow: six back-to-back writes, the sixth is dropped
    for (int i = 1; i <= 6; i++) applyStimulus(2'd0, 32'(i));
    checkOutput("t3_first_byte", {24'd0, out_port}, 32'h01);
    checkOutput("t3_first_valid", {31'd0, out_valid}, 32'd1);
    busRead(2'd1, rd); checkOutput("t3_status", rd, 32'h43);
    busRead(2'd3, rd); checkOutput("t3_event", rd, 32'h2);
    finishTransfer();
    for (int i = 2; i <= 5; i++) begin
      waitStrobeHigh("t3_byte", 8'(i));
      finishTransfer();
    end
    waitIdle();
    busRead(2'd1, rd); checkOutput("t3_status_end", rd, 32'h4);
    busRead(2'd0, rd); checkOutput("t3_last_byte", rd, 32'h05);
    applyStimulus(2'd3, 32'h3);

    // Flush during STROBE with three bytes queued
    applyStimulus(2'd0, 32'h11);
    applyStimulus(2'd0, 32'h22);
    applyStimulus(2'd0, 32'h33);
    applyStimulus(2'd0, 32'h44);
    applyStimulus(2'd1, 32'h1);
    checkOutput("t4_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t4_port", {24'd0, out_port}, 32'h11);
    busRead(2'd1, rd); checkOutput("t4_status", rd, 32'h5);
    finishTransfer();
    waitIdle();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("t4_no_more", 32'(seen), 32'd0);
    checkOutput("t4_port_hold", {24'd0, out_port}, 32'h11);
    busRead(2'd3, rd); checkOutput("t4_event", rd, 32'h1);
    applyStimulus(2'd3, 32'h3);

    // HOLD=0 gives a one-cycle strobe
    applyStimulus(2'd2, 32'h100);
    applyStimulus(2'd0, 32'h5A);
    @(posedge clk); #1;
    checkOutput("t5_port", {24'd0, out_port}, 32'h5A);
    @(posedge clk); #1;
    checkOutput("t5_valid_hi", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    checkOutput("t5_valid_lo", {31'd0, out_valid}, 32'd0);
    checkOutput("t5_irq_early", {31'd0, irq}, 32'd0);
`ifdef ZORAN_SEND_ACK_EN
    finishTransfer();
`else
    @(posedge clk); #1;
`endif
    checkOutput("t5_irq_done", {31'd0, irq}, 32'd1);
    @(negedge clk);
    applyStimulus(2'd3, 32'h3);

    // Reset in the middle of a strobe
    applyStimulus(2'd2, 32'h303);
    applyStimulus(2'd0, 32'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("t6_valid_pre", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_valid_rst", {31'd0, out_valid}, 32'd0);
    checkOutput("t6_port_rst", {24'd0, out_port}, 32'h0);
    checkOutput("t6_irq_rst", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    busRead(2'd2, rd); checkOutput("t6_config", rd, 32'h003);
    busRead(2'd1, rd); checkOutput("t6_status", rd, 32'h4);
    busRead(2'd3, rd); checkOutput("t6_event", rd, 32'h0);
    busRead(2'd0, rd); checkOutput("t6_data", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
